// File: rtl/ifid_hazard.sv
// IF/ID pipeline register with load-use stall detection and branch flush control.
// Optional build macro IFID_PERF_CNT_EN adds saturating stall/flush event counters.
module ifid_hazard #(
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] NextAdress,
    input  logic [31:0] Instr,
    input  logic        idex_MemRead,
    input  logic [4:0]  idex_RT,
    input  logic        branch_taken,
    output logic [31:0] O_NextAdress,
    output logic [31:0] O_Instr,
    output logic        O_Valid,
    output logic        PCWrite,
`ifdef IFID_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        Bubble
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI  = (FLUSH_CYCLES > 1);

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       load, nop, hazard, uses_rt, pcw_c, bub_c;
    logic [4:0] rs, rt;
    logic [5:0] op;

    assign rs = O_Instr[25:21];
    assign rt = O_Instr[20:16];
    assign op = O_Instr[31:26];

    assign uses_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd43);
    assign hazard  = O_Valid && idex_MemRead && (idex_RT != 5'd0) &&
                     ((idex_RT == rs) || (uses_rt && (idex_RT == rt)));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        nop     = 1'b0;
        pcw_c   = 1'b1;
        bub_c   = 1'b0;
        unique case (state)
            RUN, STALL: begin
                if (branch_taken) begin
                    nop     = 1'b1;
                    bub_c   = 1'b1;
                    cnt_n   = RELOAD;
                    state_n = MULTI ? FLUSH : RUN;
                end else if (state == RUN && hazard) begin
                    pcw_c   = 1'b0;
                    bub_c   = 1'b1;
                    state_n = STALL;
                end else begin
                    // STALL never re-stalls, which breaks any stall loop
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            FLUSH: begin
                nop   = 1'b1;
                bub_c = 1'b1;
                if (branch_taken) begin
                    cnt_n   = RELOAD;
                    state_n = MULTI ? FLUSH : RUN;
                end else if (cnt <= 3'd1) begin
                    cnt_n   = 3'd0;
                    state_n = RUN;
                end else begin
                    cnt_n   = cnt - 3'd1;
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = 3'd0;
            end
        endcase
    end

    // Reset forces a clean "fetch allowed, no bubble" view downstream
    assign PCWrite = pcw_c | ~rst_n;
    assign Bubble  = bub_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O_NextAdress <= 32'd0;
            O_Instr      <= NOP_WORD;
            O_Valid      <= 1'b0;
            state        <= RUN;
            cnt          <= 3'd0;
        end else begin
            if (load) begin
                O_NextAdress <= NextAdress;
                O_Instr      <= Instr;
                O_Valid      <= 1'b1;
            end else if (nop) begin
                O_Instr <= NOP_WORD;
                O_Valid <= 1'b0;
            end
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (state == RUN && state_n == STALL && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (nop && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifid_hazard.sv
// Randomized bench for ifid_hazard checked against a cycle-level behavioural model.
module tb_ifid_hazard;
    localparam int          FC  = 3;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] NextAdress, Instr;
    logic        idex_MemRead, branch_taken;
    logic [4:0]  idex_RT;
    logic [31:0] O_NextAdress, O_Instr;
    logic        O_Valid, PCWrite, Bubble;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    ifid_hazard #(.FLUSH_CYCLES(FC), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .NextAdress(NextAdress), .Instr(Instr),
        .idex_MemRead(idex_MemRead), .idex_RT(idex_RT), .branch_taken(branch_taken),
        .O_NextAdress(O_NextAdress), .O_Instr(O_Instr), .O_Valid(O_Valid),
        .PCWrite(PCWrite),
`ifdef IFID_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .Bubble(Bubble)
    );

    always #5 clk = ~clk;

    int nerr = 0, nchk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: what ID holds, whether the previous cycle was a stall, forced NOPs still owed
    logic [31:0] m_pc, m_instr;
    bit          m_valid, m_stalled;
    int          m_left, m_scnt, m_fcnt;

    task automatic m_reset();
        m_pc = 0; m_instr = NOP; m_valid = 0; m_stalled = 0;
        m_left = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    function automatic bit m_hazard(input bit mr, input logic [4:0] irt);
        int op, rs, rt;
        bit urt;
        op  = int'(m_instr[31:26]);
        rs  = int'(m_instr[25:21]);
        rt  = int'(m_instr[20:16]);
        urt = (op == 0) || (op == 4) || (op == 43);
        return m_valid && mr && irt != 0 && (int'(irt) == rs || (urt && int'(irt) == rt));
    endfunction

    task automatic check_regs(input string pfx);
        chk({pfx, "_instr"}, O_Instr, m_instr);
        chk({pfx, "_pc"}, O_NextAdress, m_pc);
        chk({pfx, "_valid"}, {31'd0, O_Valid}, {31'd0, m_valid});
`ifdef IFID_PERF_CNT_EN
        chk({pfx, "_stall_cnt"}, {16'd0, stall_cnt}, m_scnt);
        chk({pfx, "_flush_cnt"}, {16'd0, flush_cnt}, m_fcnt);
`endif
    endtask

    // One pipeline cycle: drive at negedge, check comb outputs, then registered ones after the edge
    task automatic step(input logic [31:0] na, input logic [31:0] ins,
                        input bit mr, input logic [4:0] irt, input bit br);
        int act; // 0 load, 1 nop, 2 hold
        @(negedge clk);
        NextAdress = na; Instr = ins; idex_MemRead = mr; idex_RT = irt; branch_taken = br;
        #1;
        if (br) begin act = 1; m_left = FC - 1; end
        else if (m_left > 0) begin act = 1; m_left--; end
        else if (m_hazard(mr, irt) && !m_stalled) act = 2;
        else act = 0;
        chk("pcwrite", {31'd0, PCWrite}, {31'd0, act != 2});
        chk("bubble", {31'd0, Bubble}, {31'd0, act != 0});
        @(posedge clk);
        #1;
        case (act)
            0: begin m_pc = na; m_instr = ins; m_valid = 1; m_stalled = 0; end
            1: begin m_instr = NOP; m_valid = 0; m_stalled = 0; m_fcnt++; end
            default: begin m_stalled = 1; m_scnt++; end
        endcase
        check_regs("reg");
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [5:0] ops [6];
        logic [31:0] w;
        ops[0] = 6'd0; ops[1] = 6'd4; ops[2] = 6'd43; ops[3] = 6'd35; ops[4] = 6'd8; ops[5] = 6'd2;
        w = $urandom;
        w[31:26] = ops[$urandom_range(5)];
        w[25:21] = 5'($urandom_range(3));
        w[20:16] = 5'($urandom_range(3));
        return w;
    endfunction

    initial begin
        rst_n = 0; NextAdress = 0; Instr = 0; idex_MemRead = 0; idex_RT = 0; branch_taken = 0;
        m_reset();
        #12;
        check_regs("rst");
        chk("rst_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("rst_bubble", {31'd0, Bubble}, 32'd0);
        @(negedge clk); rst_n = 1;

        // first fetch after reset
        step(32'h4, 32'h8C08_0004, 0, 0, 0);
        // load-use stall on rs of add, then release
        step(32'h8, 32'h0109_5020, 0, 0, 0);
        step(32'hC, 32'h1111_1111, 1, 5'd8, 0);
        step(32'hC, 32'h1111_1111, 0, 5'd0, 0);
        // rt-only match on addi, then zero register: no stall
        step(32'h10, 32'h212A_0001, 0, 0, 0);
        step(32'h14, 32'h000A_5020, 1, 5'd10, 0);
        step(32'h18, 32'h2222_2222, 1, 5'd0, 0);
        // branch coinciding with a hazard, then the flush tail
        step(32'h1C, 32'h0109_5020, 0, 0, 0);
        step(32'h20, 32'h3333_3333, 1, 5'd8, 1);
        for (int i = 0; i < 3; i++) step(32'h24 + 4 * i, 32'h0044_0000 + i, 0, 0, 0);
        // second branch on the 2nd flush slot extends the run
        step(32'h40, 32'h4444_4444, 0, 0, 1);
        step(32'h44, 32'h4444_4445, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(32'h48 + 4 * i, 32'h0055_0000 + i, 0, 0, 0);

        // reset asserted mid-stall, with a branch pending
        step(32'h60, 32'h0109_5020, 0, 0, 0);
        step(32'h64, 32'h6666_6666, 1, 5'd9, 0);
        @(negedge clk); rst_n = 0; branch_taken = 1; idex_MemRead = 1; idex_RT = 5'd9;
        #1;
        m_reset();
        check_regs("rst2");
        chk("rst2_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("rst2_bubble", {31'd0, Bubble}, 32'd0);
        @(negedge clk); rst_n = 1; branch_taken = 0;
        step(32'h70, 32'h7777_7777, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 500; i++)
            step($urandom, rnd_instr(), ($urandom_range(1) == 1), 5'($urandom_range(3)),
                 ($urandom_range(9) == 0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
